mem_arbiter: RTL and testbench

- Sits directly downstream of the icache and dcache.
- Serialises their miss and writeback requests onto the single-ported RAM and returns wait/load to each cache.
- Priority: dcache over icache, with a bounded-starvation guarantee for instruction fetch.
- One RAM transaction is in flight at a time. RAM-side request outputs are registered, so they are glitch-free.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache misses/writebacks onto a single-ported RAM.
// dcache has priority; icache is forced through after STARVE_LIMIT consecutive dcache wins.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    input  logic              ram_error,
    output logic              err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_starve;
    logic                r_ram_ren;
    logic                r_ram_wen;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_store;
    logic                r_err;

    logic w_dreq;
    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;
    logic w_done;
    logic w_abort;

    assign w_dreq    = dREN | dWEN;
    assign w_starved = iREN && (r_starve == LIMIT);
    assign w_grant_i = iREN && (w_starved || !w_dreq);
    assign w_grant_d = w_dreq && !w_starved;
    assign w_done    = ram_ready | ram_error;
    // Writes are never abandoned: once the RAM has been strobed it must finish.
    assign w_abort   = ((r_state == SERVE_I) && !iREN) ||
                       ((r_state == SERVE_D) && !r_ram_wen && !w_dreq);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_i) begin
                    w_next_state = SERVE_I;
                end else if (w_grant_d) begin
                    w_next_state = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (w_done || w_abort) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        iwait = 1'b1;
        dwait = 1'b1;
        iload = '0;
        dload = '0;
        if (w_done) begin
            case (r_state)
                SERVE_I: begin
                    iwait = 1'b0;
                    iload = ram_load;
                end
                SERVE_D: begin
                    dwait = 1'b0;
                    if (!r_ram_wen) begin
                        dload = ram_load;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM request lines and starvation count only change on a grant or on completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve    <= '0;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state != IDLE) && ram_error) begin
                r_err <= 1'b1;
            end
            if (r_state == IDLE) begin
                if (w_grant_i) begin
                    r_ram_ren  <= 1'b1;
                    r_ram_wen  <= 1'b0;
                    r_ram_addr <= iaddr;
                    r_starve   <= '0;
                end else if (w_grant_d) begin
                    r_ram_ren   <= !dWEN;
                    r_ram_wen   <= dWEN;
                    r_ram_addr  <= daddr;
                    r_ram_store <= dstore;
                    if (!iREN) begin
                        r_starve <= '0;
                    end else if (r_starve != LIMIT) begin
                        r_starve <= r_starve + 1'b1;
                    end
                end
            end else if (w_done || w_abort) begin
                r_ram_ren <= 1'b0;
                r_ram_wen <= 1'b0;
            end
        end
    end

    assign ram_ren   = r_ram_ren;
    assign ram_wen   = r_ram_wen;
    assign ram_addr  = r_ram_addr;
    assign ram_store = r_ram_store;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STARVE = 4;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              iREN = 1'b0;
    logic [ADDR_W-1:0] iaddr = '0;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN = 1'b0;
    logic              dWEN = 1'b0;
    logic [ADDR_W-1:0] daddr = '0;
    logic [DATA_W-1:0] dstore = '0;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic [DATA_W-1:0] ram_load = '0;
    logic              ram_ready = 1'b0;
    logic              ram_error = 1'b0;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load),
        .ram_ready(ram_ready), .ram_error(ram_error), .err(err)
    );

    always #5 CLK = ~CLK;

    // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache) and what was latched.
    int                m_owner;
    bit                m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_store;
    int                m_starve;
    bit                m_err;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner  <= 0;
            m_wr     <= 1'b0;
            m_addr   <= '0;
            m_store  <= '0;
            m_starve <= 0;
            m_err    <= 1'b0;
        end else begin
            if (m_owner != 0 && ram_error) m_err <= 1'b1;
            if (m_owner == 0) begin
                if (iREN && (m_starve == STARVE || !(dREN || dWEN))) begin
                    m_owner  <= 1;
                    m_wr     <= 1'b0;
                    m_addr   <= iaddr;
                    m_starve <= 0;
                end else if (dREN || dWEN) begin
                    m_owner  <= 2;
                    m_wr     <= dWEN;
                    m_addr   <= daddr;
                    m_store  <= dstore;
                    m_starve <= iREN ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
                end
            end else if (ram_ready || ram_error ||
                         (m_owner == 1 && !iREN) ||
                         (m_owner == 2 && !m_wr && !dREN && !dWEN)) begin
                m_owner <= 0;
            end
        end
    end

    task automatic idle_inputs();
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        ram_ready = 1'b0;
        ram_error = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRST = 1'b0;
        iREN = 1'b1;
        iaddr = 32'h0000_0100;
        ram_ready = 1'b1;
        ram_load = 32'h1234_5678;
        #1;
        n_checks++;
        if ({ram_ren, ram_wen, ram_addr, ram_store, iwait, dwait, iload, dload, err} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values: got ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b iload=%h dload=%h err=%b, expected all idle",
                     ram_ren, ram_wen, ram_addr, ram_store, iwait, dwait, iload, dload, err);
        end
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if ({ram_ren, iwait, iload} !== {1'b0, 1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL reset_held: got ren=%b iwait=%b iload=%h, expected ren=0 iwait=1 iload=0",
                     ram_ren, iwait, iload);
        end
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        n_checks++;
        if ({ram_ren, ram_wen, ram_addr, iwait, iload, dwait} !==
            {1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h1234_5678, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_first_fetch: got ren=%b wen=%b addr=%h iwait=%b iload=%h dwait=%b, expected ren=1 wen=0 addr=00000100 iwait=0 iload=12345678 dwait=1",
                     ram_ren, ram_wen, ram_addr, iwait, iload, dwait);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_checks++;
        if ({ram_ren, iwait} !== {1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset_fetch_done: got ren=%b iwait=%b, expected ren=0 iwait=1", ram_ren, iwait);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge CLK);
        iREN = 1'b1;
        iaddr = 32'h40;
        dWEN = 1'b1;
        daddr = 32'h80;
        dstore = 32'hDEAD_BEEF;
        @(negedge CLK);
        #1;
        n_checks++;
        if ({ram_ren, ram_wen, ram_addr, ram_store, iwait, dwait} !==
            {1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL simul_dcache_first: got ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b, expected ren=0 wen=1 addr=00000080 store=deadbeef waits=1",
                     ram_ren, ram_wen, ram_addr, ram_store, iwait, dwait);
        end
        ram_ready = 1'b1;
        #1;
        n_checks++;
        if ({dwait, iwait} !== {1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL simul_write_done: got dwait=%b iwait=%b, expected dwait=0 iwait=1", dwait, iwait);
        end
        @(negedge CLK);
        dWEN = 1'b0;
        ram_ready = 1'b0;
        #1;
        n_checks++;
        if ({ram_ren, ram_wen} !== 2'b00) begin
            n_errors++;
            $display("FAIL simul_gap: got ren=%b wen=%b, expected 0 0", ram_ren, ram_wen);
        end
        @(negedge CLK);
        ram_ready = 1'b1;
        ram_load = 32'h0BAD_F00D;
        #1;
        n_checks++;
        if ({ram_ren, ram_wen, ram_addr, iwait, iload} !==
            {1'b1, 1'b0, 32'h40, 1'b0, 32'h0BAD_F00D}) begin
            n_errors++;
            $display("FAIL simul_icache_next: got ren=%b wen=%b addr=%h iwait=%b iload=%h, expected ren=1 wen=0 addr=00000040 iwait=0 iload=0badf00d",
                     ram_ren, ram_wen, ram_addr, iwait, iload);
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_starvation();
        @(negedge CLK);
        iREN = 1'b1;
        iaddr = 32'h200;
        dREN = 1'b1;
        daddr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            bit exp_i;
            exp_i = (k == 4) || (k == 9);
            @(negedge CLK);
            ram_ready = 1'b1;
            ram_load = 32'h5000 + k;
            #1;
            n_checks++;
            if ({ram_ren, ram_wen, ram_addr, iwait, dwait} !==
                (exp_i ? {1'b1, 1'b0, 32'h200, 1'b0, 1'b1} : {1'b1, 1'b0, 32'h300, 1'b1, 1'b0})) begin
                n_errors++;
                $display("FAIL starve_grant_%0d: got ren=%b wen=%b addr=%h iwait=%b dwait=%b, expected %s grant",
                         k, ram_ren, ram_wen, ram_addr, iwait, dwait, exp_i ? "icache" : "dcache");
            end
            @(negedge CLK);
            ram_ready = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_rw_both();
        @(negedge CLK);
        dREN = 1'b1;
        dWEN = 1'b1;
        daddr = 32'h10;
        dstore = 32'hA5A5_A5A5;
        @(negedge CLK);
        #1;
        n_checks++;
        if ({ram_ren, ram_wen, ram_addr, ram_store} !== {1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5}) begin
            n_errors++;
            $display("FAIL rw_as_write: got ren=%b wen=%b addr=%h store=%h, expected ren=0 wen=1 addr=00000010 store=a5a5a5a5",
                     ram_ren, ram_wen, ram_addr, ram_store);
        end
        ram_ready = 1'b1;
        #1;
        n_checks++;
        if ({dwait, iwait} !== {1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL rw_done: got dwait=%b iwait=%b, expected dwait=0 iwait=1", dwait, iwait);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_checks++;
        if (ram_wen !== 1'b0) begin
            n_errors++;
            $display("FAIL rw_clear: got wen=%b, expected 0", ram_wen);
        end
    endtask

    task automatic test_abort();
        @(negedge CLK);
        iREN = 1'b1;
        iaddr = 32'h44;
        @(negedge CLK);
        iREN = 1'b0;
        #1;
        n_checks++;
        if ({ram_ren, ram_addr, iwait} !== {1'b1, 32'h44, 1'b1}) begin
            n_errors++;
            $display("FAIL abort_i_cycle: got ren=%b addr=%h iwait=%b, expected ren=1 addr=00000044 iwait=1",
                     ram_ren, ram_addr, iwait);
        end
        repeat (2) begin
            @(negedge CLK);
            #1;
            n_checks++;
            if ({ram_ren, iwait} !== {1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL abort_i_idle: got ren=%b iwait=%b, expected ren=0 iwait=1", ram_ren, iwait);
            end
        end
        dWEN = 1'b1;
        daddr = 32'h88;
        dstore = 32'h77;
        @(negedge CLK);
        dWEN = 1'b0;
        repeat (3) begin
            #1;
            n_checks++;
            if ({ram_wen, ram_addr, ram_store, dwait} !== {1'b1, 32'h88, 32'h77, 1'b1}) begin
                n_errors++;
                $display("FAIL write_not_aborted: got wen=%b addr=%h store=%h dwait=%b, expected wen=1 addr=00000088 store=00000077 dwait=1",
                         ram_wen, ram_addr, ram_store, dwait);
            end
            @(negedge CLK);
        end
        ram_ready = 1'b1;
        #1;
        n_checks++;
        if (dwait !== 1'b0) begin
            n_errors++;
            $display("FAIL write_late_done: got dwait=%b, expected 0", dwait);
        end
        @(negedge CLK);
        ram_ready = 1'b0;
        iREN = 1'b1;
        iaddr = 32'h48;
        #1;
        n_checks++;
        if (ram_wen !== 1'b0) begin
            n_errors++;
            $display("FAIL write_clear: got wen=%b, expected 0", ram_wen);
        end
        @(negedge CLK);
        iREN = 1'b0;
        ram_ready = 1'b1;
        ram_load = 32'hCAFE_0001;
        #1;
        n_checks++;
        if ({iwait, iload} !== {1'b0, 32'hCAFE_0001}) begin
            n_errors++;
            $display("FAIL abort_with_ready: got iwait=%b iload=%h, expected iwait=0 iload=cafe0001", iwait, iload);
        end
        @(negedge CLK);
        ram_ready = 1'b0;
        dREN = 1'b1;
        daddr = 32'h90;
        @(negedge CLK);
        dREN = 1'b0;
        #1;
        n_checks++;
        if ({ram_ren, ram_addr, dwait} !== {1'b1, 32'h90, 1'b1}) begin
            n_errors++;
            $display("FAIL abort_d_cycle: got ren=%b addr=%h dwait=%b, expected ren=1 addr=00000090 dwait=1",
                     ram_ren, ram_addr, dwait);
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if ({ram_ren, dwait} !== {1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL abort_d_idle: got ren=%b dwait=%b, expected ren=0 dwait=1", ram_ren, dwait);
        end
    endtask

    task automatic test_error();
        @(negedge CLK);
        dREN = 1'b1;
        daddr = 32'h20;
        @(negedge CLK);
        ram_error = 1'b1;
        ram_load = 32'hE0E0_E0E0;
        #1;
        n_checks++;
        if ({dwait, dload, iwait, err} !== {1'b0, 32'hE0E0_E0E0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL error_complete: got dwait=%b dload=%h iwait=%b err=%b, expected dwait=0 dload=e0e0e0e0 iwait=1 err=0",
                     dwait, dload, iwait, err);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_checks++;
        if ({err, ram_ren} !== {1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL error_set: got err=%b ren=%b, expected err=1 ren=0", err, ram_ren);
        end
        iREN = 1'b1;
        iaddr = 32'h30;
        @(negedge CLK);
        ram_ready = 1'b1;
        #1;
        n_checks++;
        if ({iwait, err} !== {1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL error_clean_txn: got iwait=%b err=%b, expected iwait=0 err=1", iwait, err);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL error_sticky: got err=%b, expected 1", err);
        end
        nRST = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL error_reset: got err=%b, expected 0", err);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            bit                done;
            logic              e_iwait, e_dwait, e_ren, e_wen;
            logic [DATA_W-1:0] e_iload, e_dload;
            @(negedge CLK);
            nRST = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) iREN = ~iREN;
            if ($urandom_range(0, 3) == 0) dREN = ~dREN;
            if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
            iaddr = $urandom;
            daddr = $urandom;
            dstore = $urandom;
            ram_load = $urandom;
            ram_ready = ($urandom_range(0, 9) < 3);
            ram_error = ($urandom_range(0, 49) == 0);
            #1;
            done = ram_ready || ram_error;
            e_iwait = !(m_owner == 1 && done);
            e_dwait = !(m_owner == 2 && done);
            e_iload = (m_owner == 1 && done) ? ram_load : '0;
            e_dload = (m_owner == 2 && done && !m_wr) ? ram_load : '0;
            e_ren = (m_owner == 1) || (m_owner == 2 && !m_wr);
            e_wen = (m_owner == 2) && m_wr;
            n_checks++;
            if ({iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store, err} !==
                {e_iwait, e_iload, e_dwait, e_dload, e_ren, e_wen, m_addr, m_store, m_err}) begin
                n_errors++;
                $display("FAIL random_cycle_%0d: got iw=%b il=%h dw=%b dl=%h ren=%b wen=%b addr=%h st=%h err=%b, expected iw=%b il=%h dw=%b dl=%h ren=%b wen=%b addr=%h st=%h err=%b",
                         c, iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store, err,
                         e_iwait, e_iload, e_dwait, e_dload, e_ren, e_wen, m_addr, m_store, m_err);
            end
        end
        @(negedge CLK);
        nRST = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_starvation();
        test_rw_both();
        test_abort();
        test_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
